approx_mul_share_ctrl: RTL and testbench

Arbitrated front-end that time-shares one unsigned 8x8 multiplier datapath among NREQ requesters. Each request selects an exact product or the team's 4-term approximate product. The block does round-robin arbitration, runs a 2-stage registered pipeline with valid/ready backpressure, and returns the result tagged with the requester index. It sits between accelerator lanes and the shared multiplier, so the approximate core can be characterised under real traffic.

---
 rtl/mul_share_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/approx_mul_share_ctrl.sv | 81 ++++++++
 tb/tb_approx_mul_share_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_share_pkg.sv
// mul_share_pkg: shared widths, request record and the 4-term approximate product
// used by the multiplier share controller and its scoreboard.
package mul_share_pkg;
    localparam int MUL_W   = 8;
    localparam int ZW      = 2 * MUL_W;
    localparam int MAX_IDW = 3;

    typedef struct packed {
        logic [MUL_W-1:0]   x;
        logic [MUL_W-1:0]   y;
        logic               approx;
        logic [MAX_IDW-1:0] id;
    } req_t;

    // Upper six bits of x are multiplied exactly; the two low partial products
    // are reduced to carry-like terms at weights 2^7 and 2^8.
    function automatic logic [ZW-1:0] approx_mul_f(input logic [MUL_W-1:0] x, input logic [MUL_W-1:0] y);
        logic [MUL_W-1:0] p1, p2;
        logic [ZW-1:0] c1, c2, hi;
        p1 = y & {MUL_W{x[0]}};
        p2 = y & {MUL_W{x[1]}};
        c1 = {7'd0, p1[7] & p2[6], p1[6] | p2[5], 7'd0};
        c2 = {7'd0, p2[7], p1[7] | p2[6], 7'd0};
        hi = ZW'(y) * ZW'(x[7:2]);
        return (hi << 2) + c1 + c2;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr; one-hot grant gated by en.
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);
    localparam logic [IDW:0] NQ = (IDW+1)'(NREQ);

    logic [2*NREQ-1:0] dbl;
    logic [IDW-1:0]    off;
    logic [IDW:0]      sum;

    // Rotating by ptr turns the circular scan into a lowest-set-bit search.
    always_comb begin
        dbl = {req, req} >> ptr;
        off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (dbl[k]) off = IDW'(k);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        idx = (sum >= NQ) ? sum[IDW-1:0] - NQ[IDW-1:0] : sum[IDW-1:0];
        grant = (en && |req) ? NREQ'(1) << idx : '0;
    end
endmodule

// File: rtl/approx_mul_share_ctrl.sv
// approx_mul_share_ctrl: round-robin front-end sharing one 8x8 exact/approximate
// multiplier among NREQ requesters through a 2-stage valid/ready pipeline.
module approx_mul_share_ctrl
    import mul_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int CNTW = 16,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*8-1:0]   req_x,
    input  logic [NREQ*8-1:0]   req_y,
    input  logic [NREQ-1:0]     req_approx,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [ZW-1:0]       rsp_z,
    output logic                busy,
    output logic [CNTW-1:0]     op_count
);
    logic            adv1, adv2, accept;
    logic            s1_valid, s2_valid;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  ptr, idx, s2_id;
    req_t            s1, req_sel;
    logic [ZW-1:0]   z1, s2_z;

    assign adv2 = !s2_valid || rsp_ready;
    assign adv1 = !s1_valid || adv2;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .en    (adv1),
        .grant (grant),
        .idx   (idx)
    );

    assign req_ready = grant;
    assign accept    = |grant;
    assign req_sel   = '{
        x:      req_x[{idx, 3'b000} +: MUL_W],
        y:      req_y[{idx, 3'b000} +: MUL_W],
        approx: req_approx[idx],
        id:     MAX_IDW'(idx)
    };
    assign z1 = s1.approx ? approx_mul_f(s1.x, s1.y) : ZW'(s1.x) * ZW'(s1.y);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            ptr      <= '0;
            op_count <= '0;
        end else begin
            if (adv1) s1_valid <= accept;
            if (adv2) s2_valid <= s1_valid;
            if (accept) begin
                ptr      <= (idx == IDW'(NREQ - 1)) ? '0 : idx + IDW'(1);
                op_count <= op_count + CNTW'(1);
            end
        end
    end

    // Payload registers carry no reset; their valid bits qualify them.
    always_ff @(posedge clk) begin
        if (accept) s1 <= req_sel;
        if (adv2) begin
            s2_id <= s1.id[IDW-1:0];
            s2_z  <= z1;
        end
    end

    assign rsp_valid = s2_valid;
    assign rsp_id    = s2_id;
    assign rsp_z     = s2_z;
    assign busy      = s1_valid || s2_valid;
endmodule

// File: tb/tb_approx_mul_share_ctrl.sv
// tb_approx_mul_share_ctrl: vector table, directed corner sequences and a
// scoreboard fed at every accepted request and drained at every response.
module tb_approx_mul_share_ctrl;
    import mul_share_pkg::*;

    localparam int NREQ = 4;
    localparam int CNTW = 16;
    localparam int IDW  = 2;

    logic              clk, rst_n;
    logic [NREQ-1:0]   req_valid, req_ready, req_approx;
    logic [NREQ*8-1:0] req_x, req_y;
    logic              rsp_valid, rsp_ready, busy;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       rsp_z;
    logic [CNTW-1:0]   op_count;

    approx_mul_share_ctrl #(.NREQ(NREQ), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_approx (req_approx),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_z      (rsp_z),
        .busy       (busy),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [IDW-1:0] id;
        logic [15:0]    z;
    } exp_t;

    typedef struct {
        int          id;
        logic [7:0]  x;
        logic [7:0]  y;
        logic        a;
        logic [15:0] z;
    } vec_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_acc = 0;
    int   acc_cnt[NREQ];
    int   rsp_cnt[NREQ];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        r = $urandom_range(0, 7);
        return (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : 8'($urandom_range(0, 255));
    endfunction

    // Scoreboard: push the model result on each handshake, pop on each response.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    q.push_back('{id: IDW'(i),
                                  z: req_approx[i] ? approx_mul_f(req_x[i*8 +: 8], req_y[i*8 +: 8])
                                                   : 16'(req_x[i*8 +: 8]) * 16'(req_y[i*8 +: 8])});
                    n_acc++;
                    acc_cnt[i]++;
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) chk("sb_unexpected_rsp", 1, 0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sb_id", 32'(rsp_id), 32'(e.id));
                    chk("sb_z", 32'(rsp_z), 32'(e.z));
                    rsp_cnt[rsp_id]++;
                end
            end
        end
    end

    task automatic clear_counts();
        q.delete();
        n_acc = 0;
        for (int i = 0; i < NREQ; i++) begin
            acc_cnt[i] = 0;
            rsp_cnt[i] = 0;
        end
    endtask

    vec_t tv[8];

    initial begin
        logic            acc;
        int              bp_acc, cyc, rnd_start;
        logic [15:0]     z0;
        logic [IDW-1:0]  id0;
        logic [NREQ-1:0] taken;

        tv[0] = '{0, 8'd255, 8'd255, 1'b0, 16'd65025};
        tv[1] = '{2, 8'd255, 8'd255, 1'b1, 16'd65028};
        tv[2] = '{1, 8'd3,   8'd200, 1'b1, 16'd768};
        tv[3] = '{3, 8'd3,   8'd200, 1'b0, 16'd600};
        tv[4] = '{0, 8'd0,   8'd77,  1'b1, 16'd0};
        tv[5] = '{1, 8'd16,  8'd10,  1'b1, 16'd160};
        tv[6] = '{2, 8'd7,   8'd128, 1'b1, 16'd896};
        tv[7] = '{3, 8'd1,   8'd255, 1'b1, 16'd256};

        clear_counts();
        rst_n = 1'b0;
        req_valid = '0;
        req_x = '0;
        req_y = '0;
        req_approx = '0;
        rsp_ready = 1'b1;
        #12;
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_op_count", 32'(op_count), 0);
        @(negedge clk) rst_n = 1'b1;

        // Round robin from ptr=0 with every requester asserting.
        @(posedge clk) #1;
        for (int i = 0; i < NREQ; i++) begin
            req_x[i*8 +: 8] = 8'(20 * i + 5);
            req_y[i*8 +: 8] = 8'(13 * i + 7);
            req_approx[i] = i[0];
        end
        req_valid = '1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("rr_grant", 32'(req_ready), 32'(1) << (c % NREQ));
        end
        @(posedge clk) #1 req_valid = '0;
        @(negedge clk);
        chk("rr_op_count", 32'(op_count), 6);
        repeat (4) @(negedge clk);

        // Single-op vectors with exact latency.
        for (int v = 0; v < 8; v++) begin
            @(posedge clk) #1;
            req_x[tv[v].id*8 +: 8] = tv[v].x;
            req_y[tv[v].id*8 +: 8] = tv[v].y;
            req_approx[tv[v].id] = tv[v].a;
            req_valid = NREQ'(1) << tv[v].id;
            acc = 1'b0;
            for (int w = 0; w < 20 && !acc; w++) begin
                @(negedge clk);
                acc = req_ready[tv[v].id];
            end
            chk("vec_accept", 32'(acc), 1);
            @(posedge clk) #1 req_valid = '0;
            @(negedge clk);
            chk("vec_lat_n1", 32'(rsp_valid), 0);
            @(negedge clk);
            chk("vec_rsp_valid", 32'(rsp_valid), 1);
            chk("vec_rsp_id", 32'(rsp_id), 32'(tv[v].id));
            chk("vec_rsp_z", 32'(rsp_z), 32'(tv[v].z));
        end
        repeat (3) @(negedge clk);

        // Backpressure: stall the output for three cycles during a stream.
        @(posedge clk) #1;
        for (int i = 0; i < NREQ; i++) begin
            req_x[i*8 +: 8] = 8'(37 * i + 11);
            req_y[i*8 +: 8] = 8'(251 - 29 * i);
            req_approx[i] = ~i[0];
        end
        req_valid = '1;
        repeat (3) @(negedge clk);
        @(posedge clk) #1 rsp_ready = 1'b0;
        bp_acc = 0;
        z0 = '0;
        id0 = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bp_acc += $countones(req_ready & req_valid);
            if (c == 0) begin
                chk("bp_rsp_valid", 32'(rsp_valid), 1);
                z0 = rsp_z;
                id0 = rsp_id;
            end else begin
                chk("bp_z_stable", 32'(rsp_z), 32'(z0));
                chk("bp_id_stable", 32'(rsp_id), 32'(id0));
            end
        end
        chk("bp_ready_low", 32'(req_ready), 0);
        chk("bp_accepts_le2", 32'(bp_acc <= 2), 1);
        @(posedge clk) #1 rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk) #1 req_valid = '0;
        repeat (6) @(negedge clk);
        chk("bp_drained", 32'(q.size()), 0);
        chk("bp_busy_idle", 32'(busy), 0);
        chk("bp_op_count", 32'(op_count), 32'(16'(n_acc)));

        // Asynchronous reset with both stages full.
        @(posedge clk) #1;
        req_valid = '1;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pre_busy", 32'(busy), 1);
        chk("rst_pre_rsp_valid", 32'(rsp_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_op_count", 32'(op_count), 0);
        clear_counts();
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1 req_valid = 4'b1010;
        @(negedge clk);
        chk("rst_ptr_grant1", 32'(req_ready), 32'b0010);
        @(posedge clk) #1 req_valid = 4'b1000;
        @(negedge clk);
        chk("rst_ptr_grant3", 32'(req_ready), 32'b1000);
        @(posedge clk) #1 req_valid = '0;
        repeat (4) @(negedge clk);

        // Constrained random traffic with random output stalls.
        rnd_start = n_acc;
        taken = '0;
        cyc = 0;
        while (n_acc - rnd_start < 10000 && cyc < 60000) begin
            @(posedge clk) #1;
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || taken[i]) begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    req_x[i*8 +: 8] = rand_byte();
                    req_y[i*8 +: 8] = rand_byte();
                    req_approx[i] = 1'($urandom_range(0, 1));
                end else if ($urandom_range(0, 9) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            taken = req_valid & req_ready;
            cyc++;
        end
        chk("rnd_ops_done", 32'(n_acc - rnd_start >= 10000), 1);
        @(posedge clk) #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("rnd_drained", 32'(q.size()), 0);
        for (int i = 0; i < NREQ; i++) chk("rnd_req_count", 32'(rsp_cnt[i]), 32'(acc_cnt[i]));
        chk("rnd_op_count", 32'(op_count), 32'(16'(n_acc)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
